// File: rtl/ts_pkg.sv
// ts_pkg: constants, header field positions and FSM encoding for the TS packet checker.
// Consumed by ts_checker_if, ts_sync_fsm and ts_checker through import ts_pkg::*.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam int unsigned TS_PKT_LEN   = 188;
    localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;

    // Header byte indices within a packet
    localparam int unsigned TS_HDR_PID_HI = 1;
    localparam int unsigned TS_HDR_PID_LO = 2;
    localparam int unsigned TS_HDR_CC     = 3;

    // Bit positions inside the header bytes
    localparam int unsigned TS_TEI_BIT     = 7;  // byte 1
    localparam int unsigned TS_PID_HI_MSB  = 4;  // byte 1, PID[12:8] in bits 4:0
    localparam int unsigned TS_AFC_PAY_BIT = 4;  // byte 3, afc[0] = payload present
    localparam int unsigned TS_CC_MSB      = 3;  // byte 3, CC in bits 3:0

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLock   = 2'd2
    } ts_state_e;

    // CC only advances on packets that carry payload.
    function automatic logic [3:0] ts_cc_expected(input logic [3:0] cc_ref, input logic payload);
        return payload ? cc_ref + 4'd1 : cc_ref;
    endfunction

endpackage

// File: rtl/ts_checker_if.sv
// ts_checker_if: byte-serial TS stream plus checker status/statistics bundle.
//   master: TS source / monitor side (drives DATA, D_VALID, P_SYNC, PID_FILTER).
//   slave : ts_checker side (drives LOCKED, PID_OUT, CC_OUT, pulses and counters).
// Optional TEI_CNT exists only when TS_CHECKER_TEI_EN is defined.
interface ts_checker_if #(
    parameter int unsigned CNT_W = 16
);
    logic [7:0]       DATA;
    logic             D_VALID;
    logic             P_SYNC;
    logic [12:0]      PID_FILTER;
    logic             LOCKED;
    logic [12:0]      PID_OUT;
    logic [3:0]       CC_OUT;
    logic             HDR_VALID;
    logic             SYNC_ERR;
    logic             CC_ERR;
    logic [CNT_W-1:0] PKT_CNT;
    logic [CNT_W-1:0] CC_ERR_CNT;
`ifdef TS_CHECKER_TEI_EN
    logic [CNT_W-1:0] TEI_CNT;

    modport master (
        output DATA, D_VALID, P_SYNC, PID_FILTER,
        input  LOCKED, PID_OUT, CC_OUT, HDR_VALID, SYNC_ERR, CC_ERR, PKT_CNT, CC_ERR_CNT,
        input  TEI_CNT
    );
    modport slave (
        input  DATA, D_VALID, P_SYNC, PID_FILTER,
        output LOCKED, PID_OUT, CC_OUT, HDR_VALID, SYNC_ERR, CC_ERR, PKT_CNT, CC_ERR_CNT,
        output TEI_CNT
    );
`else
    modport master (
        output DATA, D_VALID, P_SYNC, PID_FILTER,
        input  LOCKED, PID_OUT, CC_OUT, HDR_VALID, SYNC_ERR, CC_ERR, PKT_CNT, CC_ERR_CNT
    );
    modport slave (
        input  DATA, D_VALID, P_SYNC, PID_FILTER,
        output LOCKED, PID_OUT, CC_OUT, HDR_VALID, SYNC_ERR, CC_ERR, PKT_CNT, CC_ERR_CNT
    );
`endif
endinterface

// File: rtl/ts_sync_fsm.sv
// ts_sync_fsm: packet sync acquisition/tracking (HUNT -> VERIFY -> LOCK) with a flywheel
// byte index.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_data, i_valid, i_psync : TS byte, byte qualifier, packet-start marker
//   o_locked       : registered, high while in LOCK
//   o_sync_err     : 1-cycle pulse after a bad sync byte seen while locked
//   o_idx          : index of the byte currently presented (0..PKT_LEN-1)
//   o_pkt_good     : current packet had a good sync in LOCK and may be decoded
module ts_sync_fsm
    import ts_pkg::*;
#(
    parameter int unsigned PKT_LEN  = TS_PKT_LEN,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LOSS_CNT = 3,
    localparam int unsigned IDX_W   = $clog2(PKT_LEN)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    input  logic             i_psync,
    output logic             o_locked,
    output logic             o_sync_err,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_pkt_good
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKT_LEN - 1);
    localparam logic [3:0]       LOCK_THR  = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_THR  = 4'(LOSS_CNT);

    ts_state_e        r_state;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_good_cnt;
    logic [3:0]       r_miss_cnt;
    logic             r_locked;
    logic             r_sync_err;
    logic             r_pkt_good;

    logic             w_good;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [3:0]       w_good_inc;
    logic [3:0]       w_miss_inc;

    assign w_good     = (i_data == TS_SYNC_BYTE) && i_psync;
    assign w_idx_nxt  = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    assign w_good_inc = r_good_cnt + 4'd1;
    assign w_miss_inc = r_miss_cnt + 4'd1;

    always_ff @(posedge i_clk) begin
        r_sync_err <= 1'b0;
        if (i_rst) begin
            r_state    <= StHunt;
            r_idx      <= '0;
            r_good_cnt <= '0;
            r_miss_cnt <= '0;
            r_locked   <= 1'b0;
            r_pkt_good <= 1'b0;
        end else if (i_valid) begin
            unique case (r_state)
                StHunt: begin
                    if (w_good) begin
                        r_state    <= StVerify;
                        r_good_cnt <= 4'd1;
                        r_idx      <= IDX_W'(1);
                    end
                end
                StVerify: begin
                    if (r_idx == '0) begin
                        if (w_good) begin
                            r_good_cnt <= w_good_inc;
                            r_idx      <= w_idx_nxt;
                            if (w_good_inc == LOCK_THR) begin
                                // The packet that completes acquisition is decoded.
                                r_state    <= StLock;
                                r_locked   <= 1'b1;
                                r_pkt_good <= 1'b1;
                                r_miss_cnt <= '0;
                            end
                        end else begin
                            r_state    <= StHunt;
                            r_idx      <= '0;
                            r_good_cnt <= '0;
                        end
                    end else begin
                        r_idx <= w_idx_nxt;
                    end
                end
                StLock: begin
                    if (r_idx == '0) begin
                        if (w_good) begin
                            r_miss_cnt <= '0;
                            r_pkt_good <= 1'b1;
                            r_idx      <= w_idx_nxt;
                        end else begin
                            r_sync_err <= 1'b1;
                            r_pkt_good <= 1'b0;
                            if (w_miss_inc == LOSS_THR) begin
                                r_state    <= StHunt;
                                r_locked   <= 1'b0;
                                r_idx      <= '0;
                                r_miss_cnt <= '0;
                                r_good_cnt <= '0;
                            end else begin
                                // Flywheel: keep counting through the missed packet.
                                r_miss_cnt <= w_miss_inc;
                                r_idx      <= w_idx_nxt;
                            end
                        end
                    end else begin
                        r_idx <= w_idx_nxt;
                    end
                end
                default: begin
                    r_state <= StHunt;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign o_locked   = r_locked;
    assign o_sync_err = r_sync_err;
    assign o_idx      = r_idx;
    assign o_pkt_good = r_pkt_good;

endmodule

// File: rtl/ts_checker.sv
// ts_checker: MPEG-TS receive checker. Tracks packet sync, decodes the 4-byte header,
// checks continuity of one selected PID and keeps saturating statistics.
//   CLK, RST : TS byte clock, synchronous active-high reset
//   ts       : ts_checker_if.slave (DATA/D_VALID/P_SYNC/PID_FILTER in; LOCKED, PID_OUT,
//              CC_OUT, HDR_VALID, SYNC_ERR, CC_ERR, PKT_CNT, CC_ERR_CNT out)
// Optional: define TS_CHECKER_TEI_EN to add TEI_CNT and exclude TEI=1 packets from CC check.
module ts_checker
    import ts_pkg::*;
#(
    parameter int unsigned PKT_LEN  = TS_PKT_LEN,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic CLK,
    input  logic RST,
    ts_checker_if.slave ts
);

    localparam int unsigned      IDX_W    = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] IDX_PHI  = IDX_W'(TS_HDR_PID_HI);
    localparam logic [IDX_W-1:0] IDX_PLO  = IDX_W'(TS_HDR_PID_LO);
    localparam logic [IDX_W-1:0] IDX_CC   = IDX_W'(TS_HDR_CC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

    logic             w_locked;
    logic             w_sync_err;
    logic [IDX_W-1:0] w_idx;
    logic             w_pkt_good;

    ts_sync_fsm #(
        .PKT_LEN  (PKT_LEN),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) u_sync (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_data     (ts.DATA),
        .i_valid    (ts.D_VALID),
        .i_psync    (ts.P_SYNC),
        .o_locked   (w_locked),
        .o_sync_err (w_sync_err),
        .o_idx      (w_idx),
        .o_pkt_good (w_pkt_good)
    );

    logic [4:0]       r_pid_hi;
    logic [7:0]       r_pid_lo;
    logic [12:0]      r_pid_out;
    logic [3:0]       r_cc_out;
    logic             r_hdr_valid;
    logic             r_cc_err;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [CNT_W-1:0] r_cc_err_cnt;
    logic [3:0]       r_cc_ref;
    logic             r_cc_valid;
    logic             r_pid_match;
    logic [12:0]      r_pid_filter;

    logic             w_dec;
    logic [12:0]      w_pid;
    logic [3:0]       w_cc;
    logic             w_filter_chg;
    logic             w_tei_skip;
    logic             w_cc_chk;

`ifdef TS_CHECKER_TEI_EN
    logic             r_tei;
    logic [CNT_W-1:0] r_tei_cnt;
    assign w_tei_skip = r_tei;
`else
    assign w_tei_skip = 1'b0;
`endif

    assign w_dec        = ts.D_VALID && w_locked && w_pkt_good;
    assign w_pid        = {r_pid_hi, r_pid_lo};
    assign w_cc         = ts.DATA[TS_CC_MSB:0];
    assign w_filter_chg = (ts.PID_FILTER != r_pid_filter);
    assign w_cc_chk     = w_dec && (w_idx == IDX_CC) && (w_pid == ts.PID_FILTER) &&
                          (w_pid != TS_NULL_PID) && !w_tei_skip;

    always_ff @(posedge CLK) begin
        r_hdr_valid  <= 1'b0;
        r_cc_err     <= 1'b0;
        r_pid_filter <= ts.PID_FILTER;
        if (RST) begin
            r_pid_hi     <= '0;
            r_pid_lo     <= '0;
            r_pid_out    <= '0;
            r_cc_out     <= '0;
            r_pkt_cnt    <= '0;
            r_cc_err_cnt <= '0;
            r_cc_ref     <= '0;
            r_cc_valid   <= 1'b0;
            r_pid_match  <= 1'b0;
`ifdef TS_CHECKER_TEI_EN
            r_tei        <= 1'b0;
            r_tei_cnt    <= '0;
`endif
        end else begin
            // Reference dies outside LOCK or when the filter moves; a load at byte 3
            // below takes precedence in the same cycle.
            if (!w_locked || w_filter_chg) begin
                r_cc_valid <= 1'b0;
            end
            if (w_dec) begin
                if (w_idx == IDX_PHI) begin
                    r_pid_hi <= ts.DATA[TS_PID_HI_MSB:0];
`ifdef TS_CHECKER_TEI_EN
                    r_tei <= ts.DATA[TS_TEI_BIT];
                    if (ts.DATA[TS_TEI_BIT] && (r_tei_cnt != '1)) begin
                        r_tei_cnt <= r_tei_cnt + 1'b1;
                    end
`endif
                end else if (w_idx == IDX_PLO) begin
                    r_pid_lo <= ts.DATA;
                end else if (w_idx == IDX_CC) begin
                    r_pid_out   <= w_pid;
                    r_cc_out    <= w_cc;
                    r_hdr_valid <= 1'b1;
                    r_pid_match <= (w_pid == ts.PID_FILTER);
                    if (w_cc_chk) begin
                        r_cc_ref   <= w_cc;
                        r_cc_valid <= 1'b1;
                        if (r_cc_valid && !w_filter_chg &&
                            (w_cc != ts_cc_expected(r_cc_ref, ts.DATA[TS_AFC_PAY_BIT]))) begin
                            r_cc_err <= 1'b1;
                            if (r_cc_err_cnt != '1) begin
                                r_cc_err_cnt <= r_cc_err_cnt + 1'b1;
                            end
                        end
                    end
                end else if (w_idx == IDX_LAST) begin
                    if (r_pid_match && (r_pkt_cnt != '1)) begin
                        r_pkt_cnt <= r_pkt_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign ts.LOCKED     = w_locked;
    assign ts.SYNC_ERR   = w_sync_err;
    assign ts.PID_OUT    = r_pid_out;
    assign ts.CC_OUT     = r_cc_out;
    assign ts.HDR_VALID  = r_hdr_valid;
    assign ts.CC_ERR     = r_cc_err;
    assign ts.PKT_CNT    = r_pkt_cnt;
    assign ts.CC_ERR_CNT = r_cc_err_cnt;
`ifdef TS_CHECKER_TEI_EN
    assign ts.TEI_CNT    = r_tei_cnt;
`endif

endmodule

// File: tb/tb_ts_checker.sv
// tb_ts_checker: directed self-checking bench for ts_checker (default build).
module tb_ts_checker;

    logic clk;
    logic rst;

    ts_checker_if #(.CNT_W(16)) ts ();

    ts_checker dut (
        .CLK (clk),
        .RST (rst),
        .ts  (ts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_hdr    = 0;
    int n_serr   = 0;
    int n_ccerr  = 0;
    bit half     = 1'b0;

    // Snapshots taken inside send_pkt
    logic        s_lock0, s_serr0, s_hdr3, s_hdr3_idle, s_ccerr3;
    logic [12:0] s_pid3;
    logic [3:0]  s_cc3;

    always @(negedge clk) begin
        if (!rst) begin
            if (ts.HDR_VALID) n_hdr++;
            if (ts.SYNC_ERR)  n_serr++;
            if (ts.CC_ERR)    n_ccerr++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ps);
        ts.DATA    = b;
        ts.P_SYNC  = ps;
        ts.D_VALID = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Invalid cycle carrying a fake sync byte: must be ignored entirely.
    task automatic idle_cycle();
        ts.DATA    = 8'h47;
        ts.P_SYNC  = 1'b1;
        ts.D_VALID = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [12:0] pid, input logic [3:0] cc, input logic [1:0] afc,
                            input logic [7:0] sb, input bit stray, input int nbytes);
        logic [7:0] b;
        logic       ps;
        s_hdr3      = 1'b0;
        s_hdr3_idle = 1'b0;
        s_ccerr3    = 1'b0;
        for (int k = 0; k < nbytes; k++) begin
            ps = 1'b0;
            case (k)
                0: begin b = sb; ps = 1'b1; end
                1: b = {3'b000, pid[12:8]};
                2: b = pid[7:0];
                3: b = {2'b00, afc, cc};
                default: begin
                    b = 8'(k) ^ 8'h5A;
                    if (stray && k == 100) begin
                        b  = 8'h47;
                        ps = 1'b1;
                    end
                end
            endcase
            send_byte(b, ps);
            if (k == 0) begin
                s_lock0 = ts.LOCKED;
                s_serr0 = ts.SYNC_ERR;
            end
            if (k == 3) begin
                s_hdr3   = ts.HDR_VALID;
                s_pid3   = ts.PID_OUT;
                s_cc3    = ts.CC_OUT;
                s_ccerr3 = ts.CC_ERR;
            end
            if (half) begin
                idle_cycle();
                if (k == 3) s_hdr3_idle = ts.HDR_VALID;
            end
        end
        ts.D_VALID = 1'b0;
    endtask

    task automatic pkt(input logic [12:0] pid, input logic [3:0] cc);
        send_pkt(pid, cc, 2'b01, 8'h47, 1'b0, 188);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_locked"}, 32'(ts.LOCKED), 0);
        check({tag, "_pid"},    32'(ts.PID_OUT), 0);
        check({tag, "_cc"},     32'(ts.CC_OUT), 0);
        check({tag, "_hdr"},    32'(ts.HDR_VALID), 0);
        check({tag, "_serr"},   32'(ts.SYNC_ERR), 0);
        check({tag, "_ccerr"},  32'(ts.CC_ERR), 0);
        check({tag, "_pktcnt"}, 32'(ts.PKT_CNT), 0);
        check({tag, "_errcnt"}, 32'(ts.CC_ERR_CNT), 0);
    endtask

    initial begin
        ts.DATA       = 8'h00;
        ts.P_SYNC     = 1'b0;
        ts.D_VALID    = 1'b0;
        ts.PID_FILTER = 13'h100;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Acquisition: lock at byte 0 of packet 3, packets 3..12 decoded and counted.
        for (int p = 1; p <= 12; p++) begin
            pkt(13'h100, 4'(p - 1));
            if (p == 2) begin
                check("lock_p2", 32'(s_lock0), 0);
                check("hdr_p2", 32'(s_hdr3), 0);
            end
            if (p == 3) begin
                check("lock_p3", 32'(s_lock0), 1);
                check("hdr_p3", 32'(s_hdr3), 1);
                check("pid_p3", 32'(s_pid3), 32'h100);
            end
        end
        check("cc_p12", 32'(s_cc3), 11);
        check("pktcnt_acq", 32'(ts.PKT_CNT), 10);
        check("nhdr_acq", n_hdr, 10);
        check("nccerr_acq", n_ccerr, 0);

        // Continuity: 12 ok, 12->14 error, 15 ok, 15 without payload ok, 0 ok.
        pkt(13'h100, 4'd12);
        check("ccerr_12", 32'(s_ccerr3), 0);
        pkt(13'h100, 4'd14);
        check("ccerr_jump", 32'(s_ccerr3), 1);
        check("errcnt_jump", 32'(ts.CC_ERR_CNT), 1);
        pkt(13'h100, 4'd15);
        check("ccerr_after", 32'(s_ccerr3), 0);
        send_pkt(13'h100, 4'd15, 2'b10, 8'h47, 1'b0, 188);
        check("ccerr_nopay", 32'(s_ccerr3), 0);
        send_pkt(13'h200, 4'd3, 2'b01, 8'h47, 1'b1, 188);
        check("pid_other", 32'(s_pid3), 32'h200);
        pkt(13'h100, 4'd0);
        check("stray_lock", 32'(s_lock0), 1);
        check("ccerr_wrap", 32'(s_ccerr3), 0);
        check("pktcnt_cc", 32'(ts.PKT_CNT), 15);
        check("errcnt_cc", 32'(ts.CC_ERR_CNT), 1);

        // Sync loss: two misses are tolerated, three drop lock.
        send_pkt(13'h100, 4'd1, 2'b01, 8'h00, 1'b0, 188);
        check("serr_m1", 32'(s_serr0), 1);
        check("hdr_m1", 32'(s_hdr3), 0);
        send_pkt(13'h100, 4'd1, 2'b01, 8'h00, 1'b0, 188);
        check("lock_m2", 32'(s_lock0), 1);
        pkt(13'h100, 4'd1);
        check("hdr_recover", 32'(s_hdr3), 1);
        check("ccerr_recover", 32'(s_ccerr3), 0);
        send_pkt(13'h100, 4'd2, 2'b01, 8'h00, 1'b0, 188);
        send_pkt(13'h100, 4'd2, 2'b01, 8'h00, 1'b0, 188);
        check("lock_l2", 32'(s_lock0), 1);
        send_pkt(13'h100, 4'd2, 2'b01, 8'h00, 1'b0, 188);
        check("lock_l3", 32'(s_lock0), 0);
        check("serr_l3", 32'(s_serr0), 1);
        pkt(13'h100, 4'd2);
        pkt(13'h100, 4'd3);
        check("relock_2", 32'(s_lock0), 0);
        pkt(13'h100, 4'd4);
        check("relock_3", 32'(s_lock0), 1);
        check("relock_hdr", 32'(s_hdr3), 1);
        check("nserr", n_serr, 5);
        check("pktcnt_sync", 32'(ts.PKT_CNT), 17);

        // Half rate with a fake sync byte on every invalid cycle.
        half = 1'b1;
        pkt(13'h100, 4'd5);
        check("half_ccerr5", 32'(s_ccerr3), 0);
        pkt(13'h100, 4'd6);
        half = 1'b0;
        check("half_hdr", 32'(s_hdr3), 1);
        check("half_hdr_idle", 32'(s_hdr3_idle), 0);
        check("half_pid", 32'(s_pid3), 32'h100);
        check("half_cc", 32'(s_cc3), 6);
        check("half_ccerr6", 32'(s_ccerr3), 0);
        check("half_lock", 32'(ts.LOCKED), 1);
        check("pktcnt_half", 32'(ts.PKT_CNT), 19);

        // Filter change: first packet of the new PID only loads the reference.
        pkt(13'h200, 4'd8);
        ts.PID_FILTER = 13'h200;
        pkt(13'h200, 4'd9);
        check("flt_first", 32'(s_ccerr3), 0);
        check("flt_errcnt", 32'(ts.CC_ERR_CNT), 1);
        pkt(13'h100, 4'd7);
        pkt(13'h200, 4'd10);
        check("flt_next", 32'(s_ccerr3), 0);
        pkt(13'h200, 4'd12);
        check("flt_jump", 32'(s_ccerr3), 1);
        check("flt_pktcnt", 32'(ts.PKT_CNT), 22);
        check("flt_errcnt2", 32'(ts.CC_ERR_CNT), 2);

        // Null PID is counted but never CC-checked.
        ts.PID_FILTER = 13'h1FFF;
        pkt(13'h1FFF, 4'd0);
        pkt(13'h1FFF, 4'd0);
        check("null_ccerr", 32'(s_ccerr3), 0);
        check("null_pid", 32'(s_pid3), 32'h1FFF);
        check("null_pktcnt", 32'(ts.PKT_CNT), 24);
        check("nccerr_total", n_ccerr, 2);

        // Reset in the middle of a packet, then reacquire.
        ts.PID_FILTER = 13'h100;
        send_pkt(13'h100, 4'd0, 2'b01, 8'h47, 1'b0, 50);
        rst        = 1'b1;
        ts.DATA    = 8'h47;
        ts.P_SYNC  = 1'b1;
        ts.D_VALID = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        rst        = 1'b0;
        ts.D_VALID = 1'b0;
        pkt(13'h100, 4'd0);
        pkt(13'h100, 4'd1);
        check("rst_lock2", 32'(s_lock0), 0);
        pkt(13'h100, 4'd2);
        check("rst_lock3", 32'(s_lock0), 1);
        check("rst_pktcnt", 32'(ts.PKT_CNT), 1);
        check("rst_errcnt", 32'(ts.CC_ERR_CNT), 0);
`ifdef TS_CHECKER_TEI_EN
        check("tei_cnt", 32'(ts.TEI_CNT), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ts_checker.md
Name: ts_checker

Overview:
- Receive-side counterpart of the TS packet generator: consumes a byte-serial MPEG-TS stream (DATA/D_VALID/P_SYNC), acquires and tracks 188-byte packet sync, and decodes the 4-byte header.
- Checks the continuity counter for one selected PID and exposes status pulses and saturating statistics counters to the control/monitor logic.
- Sits directly behind a TS source (tuner port or generator loopback) on a single clock domain.

Parameters:
- PKT_LEN, 188, bytes per packet.
- LOCK_CNT, 3, consecutive good sync bytes needed to declare lock; range 2..15.
- LOSS_CNT, 3, consecutive bad sync bytes while locked before returning to hunt; range 1..15.
- CNT_W, 16, width of statistics counters.

Ports:
- CLK  in  1  system clock; the TS byte clock.
- RST  in  1  synchronous, active-high reset.
- DATA  in  8  TS byte.
- D_VALID  in  1  DATA/P_SYNC qualifier; a byte is "accepted" on a CLK edge with D_VALID=1.
- P_SYNC  in  1  packet-start marker, coincident with the sync byte.
- PID_FILTER  in  13  PID selected for CC checking and packet counting.
- LOCKED  out  1  packet sync acquired.
- PID_OUT  out  13  PID of the last decoded packet.
- CC_OUT  out  4  CC of the last decoded packet.
- HDR_VALID  out  1  1-cycle pulse: PID_OUT/CC_OUT updated.
- SYNC_ERR  out  1  1-cycle pulse: bad sync byte while locked.
- CC_ERR  out  1  1-cycle pulse: continuity error on the filtered PID.
- PKT_CNT  out  CNT_W  filtered-PID packets completed; saturating.
- CC_ERR_CNT  out  CNT_W  CC errors; saturating.

Behaviour:
- Reset: every output is 0, FSM is HUNT, byte index is 0, the CC reference is invalid.
- Good sync: accepted byte with DATA==8'h47 and P_SYNC==1.
- Byte index: 0..PKT_LEN-1, advances only on accepted bytes, wraps after PKT_LEN-1 to 0. It is held at 0 in HUNT.
- FSM transitions:
  - HUNT: on a good sync, go to VERIFY with good count 1 and byte index 1.
  - VERIFY: on an accepted byte at index 0, a good sync increments the count, and the FSM goes to LOCK when the count reaches LOCK_CNT. A bad sync returns the FSM to HUNT with index 0.
  - LOCK: a bad sync at index 0 increments the miss count and pulses SYNC_ERR the next cycle. The index keeps running (flywheel) and that packet is not decoded. A good sync clears the miss count. When the miss count reaches LOSS_CNT, go to HUNT with index 0.
- LOCKED is 1 exactly while the FSM is in LOCK, registered: it rises the cycle after the LOCK_CNT-th good sync is accepted.
- P_SYNC at a nonzero index is ignored.
- Header decode happens only in LOCK for packets whose sync was good:
  - Byte 1: bit7 = TEI, bits4:0 = PID[12:8].
  - Byte 2: PID[7:0].
  - Byte 3: bits5:4 = adaptation_field_control (afc), bits3:0 = CC.
- Header outputs: on acceptance of byte 3, PID_OUT and CC_OUT update and HDR_VALID pulses, all in the next cycle.
- CC check is evaluated at byte 3, only when PID==PID_FILTER and PID!=13'h1FFF:
  - If the CC reference is invalid, load it and set it valid; no error.
  - Otherwise the expected CC is ref+1 (mod 16) if afc[0]==1 (payload present), else ref.
  - On mismatch, CC_ERR pulses the next cycle and CC_ERR_CNT increments.
  - The reference always takes the received CC.
- CC reference is invalidated on leaving LOCK and on any cycle where PID_FILTER differs from its registered copy.
  - If a PID_FILTER change coincides with byte 3, the new value is used and the packet counts as first (no error).
- PKT_CNT increments on acceptance of byte PKT_LEN-1 of a decoded packet whose PID matched PID_FILTER.
- Counters saturate at all-ones; no wrap.
- D_VALID low freezes all sequential state except pulse clearing. Pulses are always single-cycle.
- Reset mid-packet: everything returns to reset state and reacquisition starts from HUNT.

Optional Feature:
- Macro TS_CHECKER_TEI_EN.
- Defined:
  - Adds output TEI_CNT (CNT_W, saturating), incremented at byte 1 of any decoded packet with TEI=1.
  - TEI=1 packets skip the CC check and leave the CC reference unchanged.
  - They are still counted in PKT_CNT.
- Undefined: TEI_CNT is absent and TEI is ignored.

Decomposition:
- Shared package ts_pkg: TS_SYNC_BYTE=8'h47, TS_PKT_LEN=188, TS_NULL_PID=13'h1FFF, header field bit positions, and the FSM state encoding (HUNT/VERIFY/LOCK).
- Natural sub-module ts_sync_fsm: FSM, byte index, and good/miss counters. It outputs LOCKED, SYNC_ERR, the current index, and a packet-good flag. Header decode and the CC check stay in the top.

Test Plan:
- Generator-like stream, PID=0x100, CC 0,1,2…, PID_FILTER=0x100 -> LOCKED rises 1 cycle after byte 0 of packet 3; HDR_VALID per packet from packet 3 with PID_OUT=0x100; CC_ERR never pulses; PKT_CNT=10 after 12 packets.
- Locked stream, CC jumps 5->7 -> CC_ERR pulse 1 cycle after that byte 3; CC_ERR_CNT=1; next CC 8 gives no error.
- Locked stream, corrupt sync to 8'h00 in 2 consecutive packets, LOSS_CNT=3 -> 2 SYNC_ERR pulses, LOCKED stays 1. Corrupt 3 consecutive -> LOCKED falls after the 3rd; relock after 3 good packets.
- D_VALID toggling 1/0 every cycle -> identical decoded results at half rate; byte index does not advance on D_VALID=0.
- PID_FILTER changed 0x100->0x200 mid-stream while 0x200 carries CC 9 -> first 0x200 packet gives no CC_ERR; CC_ERR_CNT unchanged.
- RST pulsed mid-packet -> all outputs 0 next cycle; full reacquisition follows.
